gpr_wb_queue: RTL and testbench
===============================

# gpr_wb_queue

Write-back queue on the writer side of the general-purpose register file's single write port. It accepts register-write requests from two producers, the ALU result path and the memory-load path, over valid/ready handshakes. Accepted writes are buffered in a small FIFO and drained one per cycle onto the register file's write-enable/select/data port. It also exports a per-register pending mask so decode can stall on read-after-write against writes not yet committed.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥2
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- alu_valid  in  1  ALU write request valid
- alu_ready  out  1  ALU request accepted this cycle when high with alu_valid
- alu_sel  in  5  ALU destination register
- alu_data  in  32  ALU write data
- mem_valid  in  1  load write request valid
- mem_ready  out  1  load request accepted this cycle when high with mem_valid
- mem_sel  in  5  load destination register
- mem_data  in  32  load write data
- wb_stall  in  1  register-file write port unavailable; holds the drain
- WE  out  1  register-file write enable (registered)
- WeSel  out  5  register-file write select (registered)
- WData  out  32  register-file write data (registered)
- pending  out  32  bit i high while a write to register i is queued or on the port
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Storage: DEPTH entries of {sel[4:0], data[31:0]}, with head/tail pointers of log2(DEPTH) bits, wrapping modulo DEPTH, and a count register.
- Arbitration: at most one enqueue per cycle. Load has fixed priority.
  - mem_ready = !full && !rst.
  - alu_ready = !full && !mem_valid && !rst.
  - full = (count == DEPTH).
- Handshake: a transfer occurs on the edge where valid && ready. The producer holds sel/data stable while valid && !ready. Ready never depends on the current cycle's pop.
- Register 0: a transfer with sel == 0 completes the handshake but is discarded. No enqueue, count unchanged.
- Drain, each edge:
  - If !wb_stall && count != 0: pop head into WE/WeSel/WData with WE=1.
  - Otherwise WE <= 0. WeSel/WData hold their previous value.
- Simultaneous push and pop: count unchanged, both pointers advance. Pushing when count==0 is legal; the entry becomes poppable on the following edge, with no bypass.
- Order: writes reach the port in acceptance order. Two writes to the same register commit in order, so the last accepted wins.
- pending is combinational: the OR over valid FIFO entries of onehot(sel), ORed with onehot(WeSel) when WE=1. pending[0] is always 0.
- No error outputs. Overflow cannot occur because ready gates pushes. Underflow cannot occur because pops are gated by count.

## Timing
- Reset, asynchronous: WE=0, WeSel=0, WData=0, count=0, head=tail=0, pending=0. alu_ready and mem_ready are 0 while rst is high and 1 on the first cycle after release with mem_valid=0.
- Reset mid-operation: all queued writes are discarded. Any WE pulse in flight is cleared immediately.
- Latency, unstalled, empty queue: request accepted at edge N, WE=1 from edge N+1, register-file write at edge N+2.
- Throughput: one write per cycle sustained. The queue fills only under wb_stall.
- With wb_stall high, a full queue holds mem_ready=alu_ready=0. One cycle of wb_stall low pops one entry, and ready rises in the cycle after that edge.
- pending[i] rises in the cycle after acceptance and falls in the cycle after the register-file write edge.

## Test plan
- Reset, then single ALU write sel=5 data=0xDEADBEEF at edge N -> WE=1, WeSel=5, WData=0xDEADBEEF for exactly one cycle starting at N+1; pending[5]=1 for cycles N+1..N+2, then 0.
- Both valid on the same cycle: mem (sel=3, 0x11) and alu (sel=4, 0x22) -> alu_ready=0 and mem accepted first. ALU accepted next cycle. Port shows sel 3 then sel 4 on consecutive cycles.
- wb_stall=1 with 5 ALU requests (sel 1..5, DEPTH=4) -> 4 accepted, count=4, alu_ready=0 on the fifth. Release the stall -> sel 1,2,3,4 drained in order; fifth accepted once ready rises and written after 4.
- Write to sel=0 with data 0xFFFFFFFF -> handshake completes, count stays 0, WE never asserts, pending stays 0.
- Two queued writes to sel=7 (0xA then 0xB) under stall -> pending[7] held through both. Port commits 0xA then 0xB, and pending[7] clears only after the second.
- Assert rst mid-drain with count=3 and WE=1 -> WE, count and pending go to 0 immediately, and no further WE after release.

Source files
------------

// File: rtl/gpr_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : gpr_wb_queue
//  Description : Write-back queue for the GPR file's single write port.
//                Accepts writes from the load path (priority) and the ALU
//                path, buffers them in a small FIFO and drains one per cycle
//                onto the registered WE/WeSel/WData port. It also exports a
//                per-register pending mask for read-after-write stalls.
//  Revision    : 1.0  - initial release
// ============================================================================
module gpr_wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         alu_valid,
    output logic                         alu_ready,
    input  logic [4:0]                   alu_sel,
    input  logic [31:0]                  alu_data,
    input  logic                         mem_valid,
    output logic                         mem_ready,
    input  logic [4:0]                   mem_sel,
    input  logic [31:0]                  mem_data,
    input  logic                         wb_stall,
    output logic                         WE,
    output logic [4:0]                   WeSel,
    output logic [31:0]                  WData,
    output logic [31:0]                  pending,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W  = $clog2(DEPTH + 1);

    // FIFO storage and pointers
    logic [4:0]          r_sel_mem  [DEPTH];
    logic [31:0]         r_data_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_head;
    logic [c_ADDR_W-1:0] r_tail;
    logic [c_CNT_W-1:0]  r_count;

    // Register-file port registers
    logic                r_we;
    logic [4:0]          r_wesel;
    logic [31:0]         r_wdata;

    // Handshake and datapath wires
    logic                w_full;
    logic                w_mem_fire;
    logic                w_alu_fire;
    logic [4:0]          w_push_sel;
    logic [31:0]         w_push_data;
    logic                w_push;
    logic                w_pop;
    logic [31:0]         w_pending;

    // Ready depends only on occupancy, never on the pop of the same cycle.
    assign w_full      = (r_count == c_CNT_W'(DEPTH));
    assign mem_ready   = !w_full && !rst;
    assign alu_ready   = !w_full && !mem_valid && !rst;

    assign w_mem_fire  = mem_valid && mem_ready;
    assign w_alu_fire  = alu_valid && alu_ready;
    assign w_push_sel  = w_mem_fire ? mem_sel  : alu_sel;
    assign w_push_data = w_mem_fire ? mem_data : alu_data;

    // Writes to r0 complete their handshake but are dropped here.
    assign w_push      = (w_mem_fire || w_alu_fire) && (w_push_sel != 5'd0);
    assign w_pop       = !wb_stall && (r_count != '0);

    // Entry payload write; occupancy tracking makes a reset of this array unnecessary.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_sel_mem[r_tail]  <= w_push_sel;
            r_data_mem[r_tail] <= w_push_data;
        end
    end

    // Head/tail pointers wrap naturally at the power-of-two depth; count tracks occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + c_ADDR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

    // Drain the head entry onto the write port; select and data hold while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_wesel <= 5'd0;
            r_wdata <= 32'd0;
        end else begin
            r_we <= w_pop;
            if (w_pop) begin
                r_wesel <= r_sel_mem[r_head];
                r_wdata <= r_data_mem[r_head];
            end
        end
    end

    // Pending mask: every occupied entry plus the write currently on the port.
    always_comb begin
        logic [c_ADDR_W-1:0] v_off;
        w_pending = 32'd0;
        v_off     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            // Distance of slot i from head; slots closer than count are occupied.
            v_off = c_ADDR_W'(i) - r_head;
            if (c_CNT_W'(v_off) < r_count) begin
                w_pending = w_pending | (32'd1 << r_sel_mem[i]);
            end
        end
        if (r_we) begin
            w_pending = w_pending | (32'd1 << r_wesel);
        end
        w_pending[0] = 1'b0;
    end

    assign WE      = r_we;
    assign WeSel   = r_wesel;
    assign WData   = r_wdata;
    assign pending = w_pending;
    assign count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_gpr_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpr_wb_queue
//  Description : Self-checking bench for gpr_wb_queue: directed scenarios plus
//                a randomized run against a queue-based reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_gpr_wb_queue;

    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          alu_valid, mem_valid, wb_stall;
    logic [4:0]    alu_sel, mem_sel;
    logic [31:0]   alu_data, mem_data;
    logic          alu_ready, mem_ready, WE;
    logic [4:0]    WeSel;
    logic [31:0]   WData, pending;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  sel;
        logic [31:0] data;
    } ent_t;

    // Reference model state
    ent_t        mq[$];
    logic        m_we;
    logic [4:0]  m_sel;
    logic [31:0] m_data;

    gpr_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_sel   (alu_sel),
        .alu_data  (alu_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_sel   (mem_sel),
        .mem_data  (mem_data),
        .wb_stall  (wb_stall),
        .WE        (WE),
        .WeSel     (WeSel),
        .WData     (WData),
        .pending   (pending),
        .count     (count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; mem_valid = 1'b0; wb_stall = 1'b0;
        alu_sel = 5'd0; mem_sel = 5'd0; alu_data = 32'd0; mem_data = 32'd0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
    endtask

    // Model: pop happens from the pre-edge contents, then the accepted push is appended.
    task automatic model_edge(input logic mv, input logic [4:0] ms, input logic [31:0] md,
                              input logic av, input logic [4:0] as, input logic [31:0] ad,
                              input logic st);
        logic full;
        ent_t e;
        full = (mq.size() == DEPTH);
        if (!st && mq.size() != 0) begin
            e = mq.pop_front();
            m_we = 1'b1; m_sel = e.sel; m_data = e.data;
        end else begin
            m_we = 1'b0;
        end
        if (!full && mv) begin
            if (ms != 0) mq.push_back('{ms, md});
        end else if (!full && av) begin
            if (as != 0) mq.push_back('{as, ad});
        end
    endtask

    function automatic logic [31:0] model_pending();
        logic [31:0] p;
        p = 32'd0;
        foreach (mq[i]) p[mq[i].sel] = 1'b1;
        if (m_we) p[m_sel] = 1'b1;
        p[0] = 1'b0;
        return p;
    endfunction

    task automatic test_reset();
        idle();
        rst = 1'b1;
        mem_valid = 1'b1; mem_sel = 5'd9; alu_valid = 1'b1; alu_sel = 5'd9;
        cyc();
        total++;
        if (WE !== 1'b0 || WeSel !== 5'd0 || WData !== 32'd0 || count !== '0 || pending !== 32'd0) begin
            bad++;
            $display("FAIL reset_state: WE=%b WeSel=%0d WData=%h count=%0d pending=%h, required all zero",
                     WE, WeSel, WData, count, pending);
        end
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_ready: alu_ready=%b mem_ready=%b, required 0 0", alu_ready, mem_ready);
        end
        idle();
        cyc();
        rst = 1'b0;
        #1;
        total++;
        if (alu_ready !== 1'b1 || mem_ready !== 1'b1) begin
            bad++;
            $display("FAIL release_ready: alu_ready=%b mem_ready=%b, required 1 1", alu_ready, mem_ready);
        end
    endtask

    task automatic test_single();
        do_reset();
        alu_valid = 1'b1; alu_sel = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        total++;
        if (alu_ready !== 1'b1) begin
            bad++; $display("FAIL single_ready: alu_ready=%b, required 1", alu_ready);
        end
        cyc();                       // edge N: accepted
        alu_valid = 1'b0;
        total++;
        if (WE !== 1'b0 || count !== CW'(1) || pending !== 32'h20) begin
            bad++; $display("FAIL single_N: WE=%b count=%0d pending=%h, required 0 1 00000020", WE, count, pending);
        end
        cyc();                       // edge N+1: on the port
        total++;
        if (WE !== 1'b1 || WeSel !== 5'd5 || WData !== 32'hDEADBEEF || pending !== 32'h20 || count !== '0) begin
            bad++; $display("FAIL single_N1: WE=%b WeSel=%0d WData=%h pending=%h count=%0d, required 1 5 deadbeef 00000020 0",
                            WE, WeSel, WData, pending, count);
        end
        cyc();                       // edge N+2: written
        total++;
        if (WE !== 1'b0 || pending !== 32'd0 || WeSel !== 5'd5 || WData !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_N2: WE=%b pending=%h WeSel=%0d WData=%h, required 0 0 5 deadbeef",
                            WE, pending, WeSel, WData);
        end
    endtask

    task automatic test_priority();
        do_reset();
        mem_valid = 1'b1; mem_sel = 5'd3; mem_data = 32'h11;
        alu_valid = 1'b1; alu_sel = 5'd4; alu_data = 32'h22;
        #1;
        total++;
        if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
            bad++; $display("FAIL prio_ready: alu_ready=%b mem_ready=%b, required 0 1", alu_ready, mem_ready);
        end
        cyc();
        mem_valid = 1'b0;
        #1;
        total++;
        if (alu_ready !== 1'b1) begin
            bad++; $display("FAIL prio_alu_next: alu_ready=%b, required 1", alu_ready);
        end
        cyc();
        alu_valid = 1'b0;
        total++;
        if (WE !== 1'b1 || WeSel !== 5'd3 || WData !== 32'h11) begin
            bad++; $display("FAIL prio_first: WE=%b WeSel=%0d WData=%h, required 1 3 00000011", WE, WeSel, WData);
        end
        cyc();
        total++;
        if (WE !== 1'b1 || WeSel !== 5'd4 || WData !== 32'h22) begin
            bad++; $display("FAIL prio_second: WE=%b WeSel=%0d WData=%h, required 1 4 00000022", WE, WeSel, WData);
        end
        cyc();
        total++;
        if (WE !== 1'b0 || count !== '0) begin
            bad++; $display("FAIL prio_done: WE=%b count=%0d, required 0 0", WE, count);
        end
    endtask

    task automatic test_fill();
        do_reset();
        wb_stall = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            alu_valid = 1'b1; alu_sel = 5'(k); alu_data = 32'h100 + k;
            #1;
            total++;
            if (alu_ready !== (k <= 4)) begin
                bad++; $display("FAIL fill_ready_%0d: alu_ready=%b, required %0d", k, alu_ready, (k <= 4));
            end
            if (k <= 4) cyc();
        end
        total++;
        if (count !== CW'(4) || WE !== 1'b0 || mem_ready !== 1'b0) begin
            bad++; $display("FAIL fill_full: count=%0d WE=%b mem_ready=%b, required 4 0 0", count, WE, mem_ready);
        end
        cyc();                       // still stalled: nothing moves
        total++;
        if (count !== CW'(4) || alu_ready !== 1'b0) begin
            bad++; $display("FAIL fill_hold: count=%0d alu_ready=%b, required 4 0", count, alu_ready);
        end
        wb_stall = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (i == 0) begin
                total++;
                if (alu_ready !== 1'b1 || count !== CW'(3)) begin
                    bad++; $display("FAIL fill_reopen: alu_ready=%b count=%0d, required 1 3", alu_ready, count);
                end
            end
            if (i == 1) alu_valid = 1'b0;  // sel 5 accepted on this edge
            total++;
            if (WE !== 1'b1 || WeSel !== 5'(i + 1) || WData !== 32'h101 + i) begin
                bad++; $display("FAIL fill_drain_%0d: WE=%b WeSel=%0d WData=%h, required 1 %0d %h",
                                i, WE, WeSel, WData, i + 1, 32'h101 + i);
            end
        end
        cyc();
        total++;
        if (WE !== 1'b0 || count !== '0 || pending !== 32'd0) begin
            bad++; $display("FAIL fill_empty: WE=%b count=%0d pending=%h, required 0 0 0", WE, count, pending);
        end
    endtask

    task automatic test_reg0();
        do_reset();
        alu_valid = 1'b1; alu_sel = 5'd0; alu_data = 32'hFFFFFFFF;
        #1;
        total++;
        if (alu_ready !== 1'b1) begin
            bad++; $display("FAIL reg0_ready: alu_ready=%b, required 1", alu_ready);
        end
        cyc();
        alu_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (count !== '0 || WE !== 1'b0 || pending !== 32'd0) begin
                bad++; $display("FAIL reg0_drop_%0d: count=%0d WE=%b pending=%h, required 0 0 0", i, count, WE, pending);
            end
            cyc();
        end
    endtask

    task automatic test_same_reg();
        do_reset();
        wb_stall = 1'b1;
        alu_valid = 1'b1; alu_sel = 5'd7; alu_data = 32'hA;
        cyc();
        alu_data = 32'hB;
        cyc();
        alu_valid = 1'b0;
        cyc();
        total++;
        if (pending !== 32'h80 || count !== CW'(2)) begin
            bad++; $display("FAIL same_queued: pending=%h count=%0d, required 00000080 2", pending, count);
        end
        wb_stall = 1'b0;
        cyc();
        total++;
        if (WE !== 1'b1 || WeSel !== 5'd7 || WData !== 32'hA || pending !== 32'h80) begin
            bad++; $display("FAIL same_first: WE=%b WeSel=%0d WData=%h pending=%h, required 1 7 0000000a 00000080",
                            WE, WeSel, WData, pending);
        end
        cyc();
        total++;
        if (WE !== 1'b1 || WeSel !== 5'd7 || WData !== 32'hB || pending !== 32'h80) begin
            bad++; $display("FAIL same_second: WE=%b WeSel=%0d WData=%h pending=%h, required 1 7 0000000b 00000080",
                            WE, WeSel, WData, pending);
        end
        cyc();
        total++;
        if (WE !== 1'b0 || pending !== 32'd0) begin
            bad++; $display("FAIL same_clear: WE=%b pending=%h, required 0 0", WE, pending);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wb_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            alu_valid = 1'b1; alu_sel = 5'(10 + k); alu_data = 32'h200 + k;
            cyc();
        end
        alu_valid = 1'b0;
        wb_stall = 1'b0;
        cyc();
        total++;
        if (WE !== 1'b1 || count !== CW'(3)) begin
            bad++; $display("FAIL mid_setup: WE=%b count=%0d, required 1 3", WE, count);
        end
        rst = 1'b1;
        #1;
        total++;
        if (WE !== 1'b0 || count !== '0 || pending !== 32'd0) begin
            bad++; $display("FAIL mid_async: WE=%b count=%0d pending=%h, required 0 0 0", WE, count, pending);
        end
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++;
            if (WE !== 1'b0 || count !== '0) begin
                bad++; $display("FAIL mid_after_%0d: WE=%b count=%0d, required 0 0", i, WE, count);
            end
        end
    endtask

    task automatic test_random();
        logic mv, av, st, exp_mr, exp_ar;
        logic [4:0] ms, as;
        logic [31:0] md, ad;
        do_reset();
        mq.delete();
        m_we = 1'b0; m_sel = 5'd0; m_data = 32'd0;
        for (int n = 0; n < 400; n++) begin
            exp_mr = (mq.size() != DEPTH);
            exp_ar = exp_mr && !mem_valid;
            // Producers keep their request stable until it is accepted.
            if (!(mem_valid && !exp_mr)) begin
                mem_valid = ($urandom_range(0, 99) < 35);
                mem_sel   = 5'($urandom_range(0, 7));
                mem_data  = $urandom;
            end
            if (!(alu_valid && !(exp_mr && !mem_valid))) begin
                alu_valid = ($urandom_range(0, 99) < 60);
                alu_sel   = 5'($urandom_range(0, 7));
                alu_data  = $urandom;
            end
            wb_stall = ($urandom_range(0, 99) < 40);
            #1;
            exp_mr = (mq.size() != DEPTH);
            exp_ar = exp_mr && !mem_valid;
            total++;
            if (mem_ready !== exp_mr || alu_ready !== exp_ar) begin
                bad++; $display("FAIL rand_ready_%0d: mem_ready=%b alu_ready=%b, required %b %b",
                                n, mem_ready, alu_ready, exp_mr, exp_ar);
            end
            mv = mem_valid; ms = mem_sel; md = mem_data;
            av = alu_valid; as = alu_sel; ad = alu_data; st = wb_stall;
            @(posedge clk);
            model_edge(mv, ms, md, av, as, ad, st);
            #1;
            total++;
            if (WE !== m_we || WeSel !== m_sel || WData !== m_data || count !== CW'(mq.size())
                || pending !== model_pending()) begin
                bad++; $display("FAIL rand_port_%0d: WE=%b WeSel=%0d WData=%h count=%0d pending=%h, required %b %0d %h %0d %h",
                                n, WE, WeSel, WData, count, pending, m_we, m_sel, m_data, mq.size(), model_pending());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        test_reset();
        test_single();
        test_priority();
        test_fill();
        test_reg0();
        test_same_reg();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
